// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins plus byte-stream RX/TX, status and control signals of the SPI target
// Ports: slave modport faces the target (pins/handshake inputs in, MISO/RX/status out);
//        master modport is the mirror view for an initiator or consumer.
interface spi_target_if;
  logic       spi_cen;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       clear_status;
  modport slave (
    input  spi_cen, spi_sclk, spi_mosi, rx_ready, tx_data, tx_valid, clear_status,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, frame_done,
           rx_overrun, tx_underrun
  );
  modport master (
    output spi_cen, spi_sclk, spi_mosi, rx_ready, tx_data, tx_valid, clear_status,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, frame_done,
           rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: oversampling SPI responder (modes 0/3), one byte per 8 SCLK rises, MSB first
// Ports: clk, reset (sync, active high); bus = spi_target_if.slave carrying the async SPI pins,
//        the RX byte stream (valid/ready), the 1-entry TX hold (valid/ready) and sticky status.
module spi_target #(
  parameter logic [7:0] TX_IDLE     = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  spi_target_if.slave  bus
);
  logic [SYNC_STAGES-1:0] cen_sq, sclk_sq, mosi_sq;
  logic       cen_hq, sclk_hq;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d, dlv_q, dlv_d;
  logic [7:0] shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
  logic [7:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic       full_q, full_d, rx_valid_q, rx_valid_d;
  logic       act_q, act_d, fd_q, fd_d, ovr_q, ovr_d, und_q, und_d;
  logic       cen_s, sclk_s, mosi_s, cen_fall, cen_rise, active;
  logic       sclk_rise, sclk_fall, last, load, tx_wr, ovr_evt;
  assign cen_s  = cen_sq[SYNC_STAGES-1];
  assign sclk_s = sclk_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];
  assign cen_fall = cen_hq & ~cen_s;
  assign cen_rise = ~cen_hq & cen_s;
  // requiring the history flop low as well masks SCLK edges in the cycle CEN falls
  assign active    = ~cen_s & ~cen_hq;
  assign sclk_rise = active & sclk_s & ~sclk_hq;
  assign sclk_fall = active & ~sclk_s & sclk_hq;
  assign last      = sclk_rise & (cnt_q == 3'd7);
  assign load      = cen_fall | (sclk_fall & pend_q);
  assign tx_wr     = bus.tx_valid & ~full_q;
  assign ovr_evt   = dlv_q & rx_valid_q & ~bus.rx_ready;
  always_comb begin
    shift_rx_d = sclk_rise ? {shift_rx_q[6:0], mosi_s} : shift_rx_q;
    cnt_d      = cen_rise ? 3'd0 : sclk_rise ? cnt_q + 3'd1 : cnt_q;
    pend_d     = cen_rise ? 1'b0 : last ? 1'b1 : (sclk_fall & pend_q) ? 1'b0 : pend_q;
    dlv_d      = last;
    // a write racing a load on an empty hold misses this load and waits for the next one
    shift_tx_d = load ? (full_q ? hold_q : TX_IDLE) :
                 (sclk_fall && cnt_q != 3'd0) ? {shift_tx_q[6:0], 1'b0} : shift_tx_q;
    full_d     = tx_wr | (full_q & ~load);
    hold_d     = tx_wr ? bus.tx_data : hold_q;
    rx_data_d  = (dlv_q & ~ovr_evt) ? shift_rx_q : rx_data_q;
    rx_valid_d = dlv_q | (rx_valid_q & ~bus.rx_ready);
    ovr_d      = ovr_evt | (ovr_q & ~bus.clear_status);
    und_d      = (load & ~full_q) | (und_q & ~bus.clear_status);
    act_d      = cen_fall ? 1'b1 : cen_rise ? 1'b0 : act_q;
    fd_d       = cen_rise;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cen_sq     <= '1;
      sclk_sq    <= '0;
      mosi_sq    <= '0;
      cen_hq     <= 1'b1;
      sclk_hq    <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      dlv_q      <= 1'b0;
      shift_rx_q <= '0;
      shift_tx_q <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      act_q      <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      cen_sq     <= {cen_sq[SYNC_STAGES-2:0], bus.spi_cen};
      sclk_sq    <= {sclk_sq[SYNC_STAGES-2:0], bus.spi_sclk};
      mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], bus.spi_mosi};
      cen_hq     <= cen_s;
      sclk_hq    <= sclk_s;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      dlv_q      <= dlv_d;
      shift_rx_q <= shift_rx_d;
      shift_tx_q <= shift_tx_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
      act_q      <= act_d;
      fd_q       <= fd_d;
    end
  end
  assign bus.spi_miso    = act_q & shift_tx_q[7];
  assign bus.spi_miso_oe = act_q;
  assign bus.busy        = act_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_ready    = ~full_q;
  assign bus.frame_done  = fd_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.tx_underrun = und_q;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed SPI initiator driving spi_target, RX bytes checked by a scoreboard monitor
module tb_spi_target;
  localparam int HP  = 4;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  logic [7:0] rx_exp[$];
  always #5 clk = ~clk;
  spi_target_if bus();
  spi_target u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus.frame_done) fd_cnt++;
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      if (rx_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got %0h, expected no byte", bus.rx_data);
      end else chk("rx_data", bus.rx_data, rx_exp.pop_front());
    end
  end
  task automatic xfer(input logic [7:0] mo, input logic [7:0] mi_exp, input bit cpol,
                      input int nbits, input bit lat, input int dlv_sig);
    logic [7:0] r;
    r = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (cpol) bus.spi_sclk = 1'b0;
      bus.spi_mosi = mo[i];
      tick(HP);
      bus.spi_sclk = 1'b1;
      r[i] = bus.spi_miso;
      if (i == 0) begin
        for (int j = 1; j <= LAT; j++) begin
          tick(1);
          if (lat) chk("rx_latency", bus.rx_valid, j == LAT);
          if (j == LAT - 1 && dlv_sig == 1) bus.rx_ready = 1'b1;
          if (j == LAT - 1 && dlv_sig == 2) bus.clear_status = 1'b1;
          if (j == LAT && dlv_sig == 1) bus.rx_ready = 1'b0;
          if (j == LAT && dlv_sig == 2) bus.clear_status = 1'b0;
        end
      end else tick(HP);
      if (!cpol) bus.spi_sclk = 1'b0;
    end
    if (nbits == 8) chk("miso_byte", r, mi_exp);
  endtask
  task automatic push_tx(input logic [7:0] b);
    chk("tx_ready_free", bus.tx_ready, 1);
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    chk("tx_ready_full", bus.tx_ready, 0);
  endtask
  task automatic cs_low(input bit cpol);
    bus.spi_sclk = cpol;
    tick(6);
    bus.spi_cen = 1'b0;
    tick(6);
  endtask
  task automatic cs_high(input int fd_exp);
    tick(HP);
    bus.spi_cen = 1'b1;
    tick(6);
    chk("frame_done_count", fd_cnt, fd_exp);
    chk("busy_idle", bus.busy, 0);
    chk("miso_oe_idle", bus.spi_miso_oe, 0);
  endtask
  task automatic drain();
    bus.rx_ready = 1'b1;
    tick(2);
    bus.rx_ready = 1'b0;
    chk("rx_valid_drained", bus.rx_valid, 0);
  endtask
  task automatic clear();
    bus.clear_status = 1'b1;
    tick(1);
    bus.clear_status = 1'b0;
  endtask
  task automatic reset_vals();
    chk("rst_miso", bus.spi_miso, 0);
    chk("rst_miso_oe", bus.spi_miso_oe, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_rx_overrun", bus.rx_overrun, 0);
    chk("rst_tx_underrun", bus.tx_underrun, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.spi_cen = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.rx_ready = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    bus.clear_status = 1'b0;
    tick(2);
    reset_vals();
    reset = 1'b0;
    tick(4);
    // mode 0: A5 out, 3C in; hold empties one cycle after synced CS falls
    push_tx(8'hA5);
    bus.spi_cen = 1'b0;
    tick(2);
    chk("tx_ready_before_load", bus.tx_ready, 0);
    tick(1);
    chk("tx_ready_after_load", bus.tx_ready, 1);
    chk("busy_selected", bus.busy, 1);
    chk("miso_oe_selected", bus.spi_miso_oe, 1);
    tick(3);
    rx_exp.push_back(8'h3C);
    xfer(8'h3C, 8'hA5, 1'b0, 8, 1'b1, 0);
    cs_high(1);
    drain();
    // mode 3: 81 out, 7E in; the first fall must not shift
    clear();
    bus.spi_sclk = 1'b1;
    tick(6);
    push_tx(8'h81);
    cs_low(1'b1);
    rx_exp.push_back(8'h7E);
    xfer(8'h7E, 8'h81, 1'b1, 8, 1'b1, 0);
    chk("mode3_no_underrun", bus.tx_underrun, 0);
    cs_high(2);
    bus.spi_sclk = 1'b0;
    drain();
    // three bytes, hold empty after the first, consumer stalled
    clear();
    push_tx(8'h5A);
    cs_low(1'b0);
    rx_exp.push_back(8'h11);
    xfer(8'h11, 8'h5A, 1'b0, 8, 1'b1, 0);
    xfer(8'h22, 8'hFF, 1'b0, 8, 1'b0, 0);
    xfer(8'h33, 8'hFF, 1'b0, 8, 1'b0, 0);
    chk("underrun_set", bus.tx_underrun, 1);
    chk("overrun_set", bus.rx_overrun, 1);
    chk("rx_valid_kept", bus.rx_valid, 1);
    chk("rx_data_kept", bus.rx_data, 8'h11);
    cs_high(3);
    drain();
    // aborted 5-bit frame, then a fresh frame
    clear();
    push_tx(8'h96);
    cs_low(1'b0);
    xfer(8'hFF, 8'h00, 1'b0, 5, 1'b0, 0);
    cs_high(4);
    chk("partial_no_rx_valid", bus.rx_valid, 0);
    push_tx(8'h4B);
    cs_low(1'b0);
    rx_exp.push_back(8'h55);
    xfer(8'h55, 8'h4B, 1'b0, 8, 1'b1, 0);
    cs_high(5);
    drain();
    // consume on delivery, then overrun coinciding with clear_status
    clear();
    cs_low(1'b0);
    rx_exp.push_back(8'h11);
    xfer(8'h11, 8'hFF, 1'b0, 8, 1'b1, 0);
    rx_exp.push_back(8'h22);
    xfer(8'h22, 8'hFF, 1'b0, 8, 1'b0, 1);
    chk("consume_no_overrun", bus.rx_overrun, 0);
    chk("consume_rx_data", bus.rx_data, 8'h22);
    xfer(8'h33, 8'hFF, 1'b0, 8, 1'b0, 2);
    chk("set_beats_clear", bus.rx_overrun, 1);
    clear();
    chk("clear_overrun", bus.rx_overrun, 0);
    cs_high(6);
    drain();
    // reset mid-byte, then a clean frame
    clear();
    push_tx(8'h77);
    cs_low(1'b0);
    xfer(8'hAA, 8'h00, 1'b0, 4, 1'b0, 0);
    reset = 1'b1;
    tick(1);
    reset_vals();
    bus.spi_cen = 1'b1;
    bus.spi_sclk = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    push_tx(8'hC3);
    cs_low(1'b0);
    rx_exp.push_back(8'h96);
    xfer(8'h96, 8'hC3, 1'b0, 8, 1'b1, 0);
    cs_high(7);
    drain();
    chk("scoreboard_empty", rx_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (target) for the single-bit SPI initiator used by the SoC.
- Sits on the slave end of the bus: a test fixture or external-facing peripheral port with its own byte-level streaming interface.
- All SPI pins are asynchronous. The block oversamples them on `clk`, detects SCLK edges, and shifts one byte per 8 SCLK rising edges, MSB first.
- Mode 0 and mode 3 are both supported. MOSI is sampled on SCLK rise; MISO changes on SCLK fall.

Parameters:
- `TX_IDLE`, 8'hFF: byte shifted out when no TX byte is held at a load point.
- `SYNC_STAGES`, 2: flops per pin synchronizer (>=2).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `spi_cen`  in  1  chip select, active low
- `spi_sclk`  in  1  serial clock from initiator
- `spi_mosi`  in  1  data from initiator
- `spi_miso`  out  1  data to initiator
- `spi_miso_oe`  out  1  MISO output enable; 1 only while selected
- `rx_data`  out  8  last received byte
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid` is also 1
- `tx_data`  in  8  next byte to send
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  TX holding register empty
- `busy`  out  1  synchronized CS asserted
- `frame_done`  out  1  one-cycle pulse on synchronized CS deassertion
- `rx_overrun`  out  1  sticky: received byte dropped
- `tx_underrun`  out  1  sticky: `TX_IDLE` substituted
- `clear_status`  in  1  clears both sticky flags

Behaviour:
- **Reset:** one clock, synchronous active-high reset. Reset values:
  - `spi_miso`=0, `spi_miso_oe`=0
  - `rx_data`=0, `rx_valid`=0
  - `tx_ready`=1, `busy`=0, `frame_done`=0
  - both sticky flags 0; `bit_cnt`=0
  - synchronizers: CEN=1, SCLK=0, MOSI=0
  - Reset mid-frame aborts everything. After reset, the block waits for a fresh CS falling edge.
- **Synchronization:** each pin passes through `SYNC_STAGES` flops plus one history flop for edge detection.
  - SCLK rise/fall events are valid only while synced CEN=0 and not in the cycle CEN falls.
  - Supported SCLK: half-period >= `SYNC_STAGES`+2 clk. With the default this means initiator div>=4.
- **TX holding register:** 1 entry. `tx_ready` = !full. A write occurs when `tx_valid` && `tx_ready`.
- **Load points:** (a) the cycle synced CEN falls; (b) an SCLK fall while `load_pending`=1.
  - At a load point: `shift_tx` <= held byte and the hold is emptied (`tx_ready`=1 next cycle). If the hold is empty, `shift_tx` <= `TX_IDLE` and `tx_underrun` is set.
  - A TX write in the same cycle as a load point on an empty hold counts as empty: `TX_IDLE` is used, and the written byte is kept for the next load.
  - `spi_miso` = `shift_tx[7]` whenever `spi_miso_oe`=1.
- **SCLK rise:** `shift_rx` <= {`shift_rx[6:0]`, `mosi_sync`}; `bit_cnt`++.
  - When `bit_cnt` reaches 8: `bit_cnt`<=0, `load_pending`<=1, and the byte is delivered to RX.
- **SCLK fall:**
  - If `load_pending`: perform a load and clear `load_pending`.
  - Else if `bit_cnt`>0: `shift_tx` <= {`shift_tx[6:0]`,0}.
  - Else: no change. This covers the mode-3 first fall.
- **RX delivery:** `rx_data`/`rx_valid` update in the cycle after the detected 8th rise. Latency from pin rise is `SYNC_STAGES`+2 clk.
  - If `rx_valid`=1 and `rx_ready`=0 at delivery: keep the old byte, drop the new one, set `rx_overrun`.
  - If `rx_ready`=1 in the same cycle as delivery: the old byte is consumed, the new byte is written, no overrun.
- **CS deassert:**
  - `spi_miso_oe`<=0 and `busy`<=0.
  - Partial RX bits are discarded; `bit_cnt`<=0; `load_pending`<=0.
  - The partially sent TX byte is lost. The hold register is untouched.
  - `frame_done` pulses for 1 cycle.
- **CS assert:** `busy`<=1, `spi_miso_oe`<=1, load point (a).
- **Sticky flags:** `clear_status` clears them. A set in the same cycle as a clear wins.

Test Plan:
1. Preload `tx_data`=0xA5, CS low, initiator (mode 0, div=4) sends 0x3C → initiator reads 0xA5; `rx_data`=0x3C with `rx_valid`=1 exactly 4 clk after the 8th pin rise; `tx_ready` returns 1 one cycle after CS falls.
2. Same as scenario 1 with CPOL=1 (mode 3), bytes 0x81 out / 0x7E in → initiator reads 0x81; `rx_data`=0x7E; no extra shift on the first fall.
3. Three-byte frame: hold empty before the 2nd byte; initiator sends 0x11,0x22,0x33; `rx_ready` held 0 → initiator reads [first byte, 0xFF, …]; `tx_underrun`=1; `rx_data`=0x11; `rx_overrun`=1; bytes 0x22 and 0x33 dropped.
4. CS deasserted after 5 bits, then new frame sending 0x55 → no `rx_valid` from the partial byte; one `frame_done` pulse per frame; second frame `rx_data`=0x55; MISO restarts from a freshly loaded byte.
5. `rx_ready`=1 in the same cycle as delivery of byte 2 (0x22) over an unconsumed byte 1 (0x11) → 0x11 consumed, `rx_data`=0x22, `rx_overrun` stays 0; `clear_status` and an overrun event in the same cycle → flag reads 1.
6. `reset` asserted mid-byte, then a new CS frame with TX 0xC3 / RX 0x96 → all outputs at reset values the next cycle; new frame transfers 0xC3 / 0x96 correctly.
